digital_clock_settable: RTL

Parametrised 24-hour timekeeper with user time-set mode, selectable 12/24-hour display and blinking edit field. Drives six 7-segment digits (HH:MM:SS) and an AM/PM indicator. Sits directly between the board clock/push-button conditioning logic and the display pins. Button inputs arrive as single-cycle pulses that are already debounced.

---
 rtl/digital_clock_settable.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/digital_clock_settable.sv
// Settable 24-hour HH:MM:SS timekeeper driving six 7-segment digits.
// RUN counts seconds from a CLK_HZ prescaler; mode_btn steps through SET_HR/SET_MIN/SET_SEC,
// where inc_btn bumps only the selected field and that field blinks.
// Display outputs are registered (one cycle behind the internal state).
module digital_clock_settable #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned BLINK_HZ       = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       fmt_12h,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       pm_led,
  output logic       sec_tick,
  output logic       edit_active
);

  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BlinkMax = BW'(HALF - 1);
  localparam logic [6:0]    SegOff   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {StRun, StSetHr, StSetMin, StSetSec} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;
  logic [41:0]   segs_q, segs_d;
  logic          pm_q, pm_d;
  logic          edit_q, edit_d;

  logic [4:0]    disp_hr;
  logic [3:0]    hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;

  function automatic logic [3:0] div10(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [5:0] v);
    logic [5:0] t;
    t = {2'b00, div10(v)} * 6'd10;
    return 4'(v - t);
  endfunction

  // Active-high {g,f,e,d,c,b,a} pattern, blanked on request, then polarity applied.
  function automatic logic [6:0] enc(input logic [3:0] d, input logic blank);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    if (blank) p = 7'h00;
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      tick_q      <= 1'b0;
      segs_q      <= {6{SegOff}};
      pm_q        <= 1'b0;
      edit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      segs_q      <= segs_d;
      pm_q        <= pm_d;
      edit_q      <= edit_d;
    end
  end

  // Next state: each mode pulse advances around the RUN/SET ring
  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      unique case (state_q)
        StRun:    state_d = StSetHr;
        StSetHr:  state_d = StSetMin;
        StSetMin: state_d = StSetSec;
        StSetSec: state_d = StRun;
      endcase
    end
  end

  // Prescaler, time counters, field editing and blink phase
  always_comb begin
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    tick_d      = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_q == StRun) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
      // A simultaneous mode pulse discards the increment
      if (inc_btn && !mode_btn) begin
        case (state_q)
          StSetHr:  hr_d  = (hr_q == 5'd23)  ? 5'd0 : hr_q + 5'd1;
          StSetMin: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          StSetSec: sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          default:  ;
        endcase
      end
    end
    if ((state_d != state_q) || (state_q == StRun)) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Display decode feeding the registered outputs
  always_comb begin
    disp_hr = hr_q;
    if (fmt_12h) begin
      if (hr_q == 5'd0)       disp_hr = 5'd12;
      else if (hr_q > 5'd12)  disp_hr = hr_q - 5'd12;
    end
    hr_tens  = div10({1'b0, disp_hr});
    hr_ones  = mod10({1'b0, disp_hr});
    min_tens = div10(min_q);
    min_ones = mod10(min_q);
    sec_tens = div10(sec_q);
    sec_ones = mod10(sec_q);
    segs_d[41:35] = enc(hr_tens, (blink_q && state_q == StSetHr) ||
                                 (fmt_12h && hr_tens == 4'd0));
    segs_d[34:28] = enc(hr_ones,  blink_q && state_q == StSetHr);
    segs_d[27:21] = enc(min_tens, blink_q && state_q == StSetMin);
    segs_d[20:14] = enc(min_ones, blink_q && state_q == StSetMin);
    segs_d[13:7]  = enc(sec_tens, blink_q && state_q == StSetSec);
    segs_d[6:0]   = enc(sec_ones, blink_q && state_q == StSetSec);
    pm_d   = fmt_12h && (hr_q >= 5'd12);
    edit_d = (state_q != StRun);
  end

  assign seg5        = segs_q[41:35];
  assign seg4        = segs_q[34:28];
  assign seg3        = segs_q[27:21];
  assign seg2        = segs_q[20:14];
  assign seg1        = segs_q[13:7];
  assign seg0        = segs_q[6:0];
  assign pm_led      = pm_q;
  assign sec_tick    = tick_q;
  assign edit_active = edit_q;

endmodule
